// File: rtl/cover_toggle_collector.sv
// ============================================================================
// Module   : cover_toggle_collector
// Purpose  : Sticky toggle-coverage hit map; streams each point's first hit once
//            as a global cover index. Optional macro: COVER_COLLECT_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cover_toggle_collector #(
  parameter int WIDTH       = 3,
  parameter int COVER_TOTAL = 10906,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_index,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         all_hit
);

  localparam int CNT_W = $clog2(WIDTH+1);

  generate
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
      $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end
  endgenerate

  logic [WIDTH-1:0] r_hit;
  logic [WIDTH-1:0] r_pending;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_index;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_new;
  logic [WIDTH-1:0] w_load_mask;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_found;
  logic             w_load_en;
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_count_next;
  logic             w_clr;

`ifdef COVER_COLLECT_CLEAR_EN
  assign w_clr = clear;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear;
  assign w_clr          = 1'b0;
`endif

  assign w_new     = valid & ~r_hit;
  assign w_load_en = !r_out_valid || out_ready;

  // Priority pick of the lowest registered pending bit; fresh hits wait one edge.
  always_comb begin
    w_found     = 1'b0;
    w_load_mask = '0;
    w_load_idx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_pending[i] && !w_found) begin
        w_found        = 1'b1;
        w_load_mask[i] = 1'b1;
        w_load_idx     = IDX_W'(COVER_INDEX) + IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CNT_W'(w_new[i]);
    end
    w_sum = {1'b0, r_count} + {1'b0, w_pop};
    if (w_sum > (CNT_W+1)'(WIDTH)) begin
      w_count_next = CNT_W'(WIDTH);
    end else begin
      w_count_next = w_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hit       <= '0;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_count     <= '0;
    end else if (w_clr) begin
      r_hit       <= '0;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_count     <= '0;
    end else begin
      r_hit   <= r_hit | w_new;
      r_count <= w_count_next;
      if (w_load_en) begin
        r_pending   <= (r_pending & ~w_load_mask) | w_new;
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_index <= w_load_idx;
        end
      end else begin
        r_pending <= r_pending | w_new;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign hit_count = r_count;
  assign all_hit   = (r_count == CNT_W'(WIDTH));

endmodule

`default_nettype wire

// File: tb/tb_cover_toggle_collector.sv
// ============================================================================
// Module   : tb_cover_toggle_collector
// Purpose  : Directed self-checking bench for cover_toggle_collector (COVER_INDEX=100).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cover_toggle_collector;

  localparam int WIDTH = 3;
  localparam int CNT_W = $clog2(WIDTH+1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] valid = '0;
  logic             clear = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_index;
  logic [CNT_W-1:0] hit_count;
  logic             all_hit;

  int nchecks = 0;
  int nerrors = 0;
  int ntx;
  logic [63:0] rec [0:7];

  cover_toggle_collector #(
    .WIDTH(WIDTH), .COVER_TOTAL(10906), .COVER_INDEX(100), .IDX_W(64)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .hit_count(hit_count), .all_hit(all_hit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = '0;
    clear = 1'b0;
    out_ready = 1'b0;
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_index", out_index, 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    chk("rst_all_hit", 64'(all_hit), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // One-cycle 101 with ready high
    out_ready = 1'b1;
    valid = 3'b101;
    tick();
    valid = 3'b000;
    chk("t1_count_after_edge", 64'(hit_count), 64'd2);
    chk("t1_latency_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("t1_c2_valid", 64'(out_valid), 64'd1);
    chk("t1_c2_index", out_index, 64'd100);
    tick();
    chk("t1_c3_valid", 64'(out_valid), 64'd1);
    chk("t1_c3_index", out_index, 64'd102);
    tick();
    chk("t1_drained", 64'(out_valid), 64'd0);
    chk("t1_hit_count", 64'(hit_count), 64'd2);
    chk("t1_all_hit", 64'(all_hit), 64'd0);

    // 111 held for 10 cycles: exactly three ordered transfers
    do_reset();
    out_ready = 1'b1;
    valid = 3'b111;
    ntx = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) chk("t2_all_hit_c1", 64'(all_hit), 64'd1);
      if (k == 10) valid = 3'b000;
      if (out_valid && out_ready) begin
        if (ntx < 8) rec[ntx] = out_index;
        ntx++;
      end
    end
    chk("t2_num_transfers", 64'(ntx), 64'd3);
    chk("t2_tx0", rec[0], 64'd100);
    chk("t2_tx1", rec[1], 64'd101);
    chk("t2_tx2", rec[2], 64'd102);
    chk("t2_count", 64'(hit_count), 64'd3);

    // Backpressure: stall 5 cycles on index 100
    do_reset();
    valid = 3'b111;
    tick();
    valid = 3'b000;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_valid", 64'(out_valid), 64'd1);
      chk("t3_stall_index", out_index, 64'd100);
      tick();
    end
    chk("t3_stall_end_index", out_index, 64'd100);
    out_ready = 1'b1;
    tick();
    chk("t3_rel_101", out_index, 64'd101);
    chk("t3_rel_101_v", 64'(out_valid), 64'd1);
    tick();
    chk("t3_rel_102", out_index, 64'd102);
    tick();
    chk("t3_rel_done", 64'(out_valid), 64'd0);

    // New hit on bit 2 while 100 is stalled; repeat hit later
    do_reset();
    valid = 3'b001;
    tick();
    valid = 3'b000;
    tick();
    chk("t4_held_100", out_index, 64'd100);
    valid = 3'b100;
    tick();
    valid = 3'b000;
    chk("t4_still_100", out_index, 64'd100);
    chk("t4_count", 64'(hit_count), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("t4_next_102", out_index, 64'd102);
    chk("t4_next_102_v", 64'(out_valid), 64'd1);
    tick();
    chk("t4_empty", 64'(out_valid), 64'd0);
    valid = 3'b101;
    tick();
    valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_dup", 64'(out_valid), 64'd0);
    end
    chk("t4_count_unchanged", 64'(hit_count), 64'd2);

    // Asynchronous reset between edges
    do_reset();
    valid = 3'b111;
    tick();
    valid = 3'b000;
    tick();
    chk("t5_before_rst", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_drop", 64'(out_valid), 64'd0);
    chk("t5_count_zero", 64'(hit_count), 64'd0);
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    valid = 3'b001;
    tick();
    valid = 3'b000;
    tick();
    chk("t5_rehit_valid", 64'(out_valid), 64'd1);
    chk("t5_rehit_100", out_index, 64'd100);

    // Clear with simultaneous valid after all points hit
    do_reset();
    out_ready = 1'b1;
    valid = 3'b111;
    tick();
    valid = 3'b000;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_pre_empty", 64'(out_valid), 64'd0);
    chk("t6_pre_count", 64'(hit_count), 64'd3);
    clear = 1'b1;
    valid = 3'b010;
    tick();
    clear = 1'b0;
    valid = 3'b000;
`ifdef COVER_COLLECT_CLEAR_EN
    chk("t6_clr_count", 64'(hit_count), 64'd0);
    chk("t6_clr_all_hit", 64'(all_hit), 64'd0);
`else
    chk("t6_noclr_count", 64'(hit_count), 64'd3);
    chk("t6_noclr_all_hit", 64'(all_hit), 64'd1);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_emit", 64'(out_valid), 64'd0);
    end
    valid = 3'b010;
    tick();
    valid = 3'b000;
    tick();
`ifdef COVER_COLLECT_CLEAR_EN
    chk("t6_reemit_v", 64'(out_valid), 64'd1);
    chk("t6_reemit_101", out_index, 64'd101);
    chk("t6_count_one", 64'(hit_count), 64'd1);
`else
    chk("t6_no_reemit", 64'(out_valid), 64'd0);
    chk("t6_count_sticky", 64'(hit_count), 64'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

`default_nettype wire
